fpadd_share_arbiter: RTL and testbench
======================================

// Module: fpadd_share_arbiter
// PURPOSE
//  Shares one pipelined FP adder (fixed LATENCY, clk_en-gated, 32-bit IEEE-754) among NREQ requesters.
//  Round-robin arbiter issues at most one add per enabled cycle.
//  A tag pipeline matched to the adder latency routes each result back to its issuer.
//  Sits between PE-group add requesters and the single adder instance inside the custom-instruction block.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  LATENCY  10  adder pipeline depth in enabled clocks; tag pipeline depth
//  IDW      2   requester-id width, = clog2(NREQ)
// PORTS
//  clk          input   1        clock
//  reset        input   1        asynchronous active-low reset
//  clk_en       input   1        global enable; low freezes arbiter, tag pipe and adder
//  req_valid    input   NREQ     per-requester operation request
//  req_dataa    input   NREQ*32  operand A, requester i at [32*i+:32]
//  req_datab    input   NREQ*32  operand B, requester i at [32*i+:32]
//  req_ready    output  NREQ     one-hot grant; op i accepted when req_valid[i]&req_ready[i]
//  add_dataa    output  32       to adder dataa
//  add_datab    output  32       to adder datab
//  add_clk_en   output  1        to adder clk_en (= clk_en)
//  add_aclr     output  1        to adder aclr (= ~reset)
//  add_result   input   32       from adder result
//  rsp_valid    output  NREQ     one-hot, one-cycle result strobe per requester
//  rsp_result   output  32       = add_result; meaningful only when |rsp_valid
//  rsp_id       output  IDW      id of returning requester; 0 when no result
//  inflight     output  clog2(LATENCY+1)  count of valid tag-pipe stages
//  busy         output  1        inflight != 0
// BEHAVIOUR
//  Reset (reset=0, async):
//   - rr_ptr=NREQ-1; all tag stages invalid, id=0.
//   - req_ready=0, rsp_valid=0, rsp_id=0, inflight=0, busy=0.
//   - add_dataa/add_datab = 0 while reset low.
//  Arbitration (combinational, per cycle):
//   - Search req_valid from index rr_ptr+1 upward, wrapping mod NREQ; first hit = winner.
//   - req_ready = onehot(winner) & {NREQ{clk_en}}; all zero if no request or clk_en=0.
//   - add_dataa/add_datab = winner's operands; if no winner, hold operands of requester rr_ptr
//     (tag marks the slot invalid, so the value is don't-care).
//   - On an enabled edge with an issue, rr_ptr <= winner; otherwise unchanged.
//   - Requester must hold req_valid/operands until accepted; dropping req_valid before grant is
//     legal (no issue).
//  Tag pipeline (LATENCY stages of {v, id}):
//   - Advances only on edges with clk_en=1.
//   - Stage0 <= {issue, winner}; stage k <= stage k-1.
//   - Issue at enabled edge E: adder result is valid after enabled edge E+LATENCY-1, aligned with
//     the stage[LATENCY-1] tag.
//  Response:
//   - rsp_valid[i] = stage[LATENCY-1].v & (stage[LATENCY-1].id==i) & clk_en.
//   - rsp_id = stage[LATENCY-1].id when rsp_valid nonzero, else 0.
//   - clk_en low: rsp_valid=0 and the tail is held; the result is reported on the next clk_en=1 cycle.
//   - Each issued op is reported exactly once, in issue order.
//   - No response backpressure: requesters must sample rsp_result on their strobe.
//  inflight:
//   - Updated on enabled edges: +1 on issue, -1 when tail valid, unchanged if both or neither.
//   - Never exceeds LATENCY.
//  Boundary cases:
//   - Throughput is one issue per enabled cycle; issue and retire in the same cycle are legal.
//   - A lone requester is granted every enabled cycle.
//   - Reset mid-operation discards all in-flight tags; no rsp_valid is ever produced for them.
//   - clk_en toggling mid-flight preserves alignment; results are lost only by reset.
// TESTING
//  T1 single op:
//   - req_valid=0001, A=0x3F800000 (1.0), B=0x40000000 (2.0).
//   - req_ready[0]=1 that cycle; rsp_valid=0001 with rsp_result 0x40400000 (3.0) LATENCY cycles
//     later; inflight 1 -> 0.
//  T2 round-robin:
//   - req_valid=1111 held for 8 cycles.
//   - Grants in order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle; inflight
//     peaks at 8.
//  T3 skip idle:
//   - rr_ptr=0, req_valid=1010.
//   - Grant 1, then 3, then 1; requesters 0 and 2 never strobed.
//  T4 stall:
//   - Issue 3 ops, then drop clk_en for 5 cycles mid-flight.
//   - No req_ready/rsp_valid while clk_en=0; all 3 results arrive intact and in order, delayed
//     exactly 5 cycles.
//  T5 reset mid-flight:
//   - 6 ops in flight, pulse reset low for 1 cycle.
//   - req_ready, rsp_valid and inflight go 0 immediately; no stale rsp_valid over the next
//     LATENCY+2 cycles.
//  T6 full pipe:
//   - Continuous issue from 2 requesters for 3*LATENCY cycles.
//   - inflight saturates at LATENCY; every result matches the scoreboard sum and id.

Source files
------------

// File: rtl/fpadd_share_arbiter.sv
// fpadd_share_arbiter: round-robin sharing of one pipelined FP adder among
// NREQ requesters. A {valid,id} tag pipe matched to the adder latency steers
// each result back to the requester that issued it.
module fpadd_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 10,
    parameter int IDW     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*32-1:0]            req_dataa,
    input  logic [NREQ*32-1:0]            req_datab,
    output logic [NREQ-1:0]               req_ready,
    output logic [31:0]                   add_dataa,
    output logic [31:0]                   add_datab,
    output logic                          add_clk_en,
    output logic                          add_aclr,
    input  logic [31:0]                   add_result,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [31:0]                   rsp_result,
    output logic [IDW-1:0]                rsp_id,
    output logic [$clog2(LATENCY+1)-1:0]  inflight,
    output logic                          busy
);

    localparam int CW = $clog2(LATENCY+1);

    logic [IDW-1:0]                r_rr_ptr;
    logic [LATENCY-1:0]            r_vld_pipe;
    logic [LATENCY-1:0][IDW-1:0]   r_id_pipe;
    logic [CW-1:0]                 r_inflight;

    logic                          w_found;
    logic [IDW-1:0]                w_winner;
    logic [IDW-1:0]                w_sel;
    logic                          w_issue;
    logic [NREQ-1:0]               w_gnt;
    logic                          w_tail_v;
    logic [IDW-1:0]                w_tail_id;
    logic                          w_retire;
    logic [NREQ-1:0]               w_rsp;

    // Round-robin search starting just after the last winner, wrapping mod NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // An issue needs a winner, an enabled cycle and reset released.
    assign w_issue = w_found & clk_en & reset;

    // One-hot grant to the winner.
    always_comb begin
        w_gnt = '0;
        if (w_issue) w_gnt[w_winner] = 1'b1;
    end
    assign req_ready = w_gnt;

    // With no winner the operands of rr_ptr are presented; the invalid tag
    // makes that slot's result a don't-care.
    assign w_sel      = w_found ? w_winner : r_rr_ptr;
    assign add_dataa  = reset ? req_dataa[32*w_sel +: 32] : '0;
    assign add_datab  = reset ? req_datab[32*w_sel +: 32] : '0;
    assign add_clk_en = clk_en;
    assign add_aclr   = ~reset;

    // Pointer follows the most recent winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_rr_ptr <= IDW'(NREQ-1);
        else if (w_issue) r_rr_ptr <= w_winner;
    end

    // Tag pipe advances in lockstep with the adder so the tail lines up with add_result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else if (clk_en) begin
            r_vld_pipe <= {r_vld_pipe[LATENCY-2:0], w_issue};
            r_id_pipe  <= {r_id_pipe[LATENCY-2:0], w_winner};
        end
    end

    assign w_tail_v  = r_vld_pipe[LATENCY-1];
    assign w_tail_id = r_id_pipe[LATENCY-1];
    assign w_retire  = w_tail_v & clk_en;

    // Result strobe goes only to the issuer, and only on enabled cycles.
    always_comb begin
        w_rsp = '0;
        if (w_retire) w_rsp[w_tail_id] = 1'b1;
    end
    assign rsp_valid  = w_rsp;
    assign rsp_id     = w_retire ? w_tail_id : '0;
    assign rsp_result = add_result;

    // Occupancy count: +1 on issue, -1 on retire, both cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else if (clk_en) begin
            case ({w_issue, w_tail_v})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end
    assign inflight = r_inflight;
    assign busy     = (r_inflight != '0);

endmodule

// File: tb/tb_fpadd_share_arbiter.sv
// Directed bench for fpadd_share_arbiter with a behavioural pipelined FP adder.
// Each requester i adds A=(i+1).0 and B=2.0, so its result is (i+3).0.
module tb_fpadd_share_arbiter;

    localparam int NREQ    = 4;
    localparam int LATENCY = 10;
    localparam int IDW     = 2;
    localparam int CW      = $clog2(LATENCY+1);

    logic                clk, reset, clk_en;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid;
    logic [NREQ*32-1:0]  req_dataa, req_datab;
    logic [31:0]         add_dataa, add_datab, add_result, rsp_result;
    logic                add_clk_en, add_aclr, busy;
    logic [IDW-1:0]      rsp_id;
    logic [CW-1:0]       inflight;

    fpadd_share_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab),
        .req_ready(req_ready), .add_dataa(add_dataa), .add_datab(add_datab),
        .add_clk_en(add_clk_en), .add_aclr(add_aclr), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_id(rsp_id),
        .inflight(inflight), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single <-> double conversion, exact for the small normal values used here.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural adder: LATENCY enabled stages, async clear.
    logic [31:0] apipe [LATENCY];
    always @(posedge clk or posedge add_aclr) begin
        if (add_aclr) begin
            for (int k = 0; k < LATENCY; k++) apipe[k] <= '0;
        end else if (add_clk_en) begin
            apipe[0] <= r2f(f2r(add_dataa) + f2r(add_datab));
            for (int k = 1; k < LATENCY; k++) apipe[k] <= apipe[k-1];
        end
    end
    assign add_result = apipe[LATENCY-1];

    logic [31:0] op_a    [NREQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] exp_sum [NREQ] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

    typedef struct { int id; int cnt; } ent_t;
    ent_t q[$];
    int   en_cnt = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: sample at negedge, check grant/occupancy/response, then advance.
    task automatic step(input logic [NREQ-1:0] exp_gnt);
        logic [NREQ-1:0] ev;
        int              eid;
        ent_t            e;
        @(negedge clk);
        chk("gnt", 32'(req_ready), 32'(exp_gnt));
        chk("inflight", 32'(inflight), 32'(q.size()));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        ev  = '0;
        eid = 0;
        if (clk_en && q.size() > 0 && q[0].cnt + LATENCY <= en_cnt) begin
            e   = q.pop_front();
            ev[e.id] = 1'b1;
            eid = e.id;
            chk("rsp_lat", 32'(en_cnt), 32'(e.cnt + LATENCY));
            chk("rsp_result", rsp_result, exp_sum[e.id]);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        for (int i = 0; i < NREQ; i++)
            if (exp_gnt[i]) q.push_back('{id: i, cnt: en_cnt});
        if (clk_en) en_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        for (int k = 0; k < LATENCY + 4 && q.size() > 0; k++) step('0);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_dataa[32*i +: 32] = op_a[i];
            req_datab[32*i +: 32] = 32'h40000000;
        end
        clk_en    = 1'b1;
        req_valid = '1;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #10;
        // Reset state with every requester asking.
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dataa", add_dataa, 32'd0);
        chk("rst_datab", add_datab, 32'd0);
        chk("rst_aclr", 32'(add_aclr), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = '0;
        #1;
        chk("aclr_off", 32'(add_aclr), 32'd0);
        chk("add_clk_en", 32'(add_clk_en), 32'd1);

        // T1: single op from requester 0, 1.0 + 2.0.
        req_valid = 4'b0001;
        step(4'b0001);
        drain();

        // T2: all requesting for 8 cycles, rr_ptr=0 so order starts at 1.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) step(NREQ'(1) << ((1 + k) % NREQ));
        drain();

        // T3: rr_ptr=0, only 1 and 3 asking.
        req_valid = 4'b1010;
        step(4'b0010);
        step(4'b1000);
        step(4'b0010);
        drain();

        // T4: three ops from rr_ptr=1, then a 5-cycle clk_en stall mid-flight.
        req_valid = 4'b1111;
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        req_valid = '0;
        step('0);
        step('0);
        clk_en    = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) step('0);
        chk("stall_add_clk_en", 32'(add_clk_en), 32'd0);
        clk_en = 1'b1;
        drain();

        // T5: six ops in flight from rr_ptr=0, then a one-cycle reset pulse.
        req_valid = 4'b1111;
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        reset = 1'b0;
        #1;
        chk("t5_ready", 32'(req_ready), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_inflight", 32'(inflight), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = '0;
        for (int k = 0; k < LATENCY + 2; k++) step('0);

        // T6: requesters 0 and 2 continuously for 3*LATENCY cycles, rr_ptr=3.
        req_valid = 4'b0101;
        for (int k = 0; k < 3 * LATENCY; k++) step((k % 2 == 0) ? 4'b0001 : 4'b0100);
        chk("t6_sat", 32'(inflight), 32'(LATENCY));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
